// File: rtl/master_spi_multi_if.sv
// I/O strobe bus plus shared SPI pins for master_spi_multi.
// slave modport is the SPI engine's view; master modport is the host/SPI-slave side.
interface master_spi_multi_if #(
  parameter int NCS = 4
);
  logic [7:0]     D_in;
  logic [7:0]     D_out;
  logic [15:0]    A;
  logic           IOWR;
  logic           IORD;
  logic           DDIR;
  logic           WAIT;
  logic [NCS-1:0] SS;
  logic           SCLK;
  logic           MOSI;
  logic           MISO;

  modport slave (
    input  D_in, A, IOWR, IORD, MISO,
    output D_out, DDIR, WAIT, SS, SCLK, MOSI
  );

  modport master (
    output D_in, A, IOWR, IORD, MISO,
    input  D_out, DDIR, WAIT, SS, SCLK, MOSI
  );
endinterface

// File: rtl/master_spi_multi.sv
// SPI master on the 8-bit I/O strobe bus: NCS chip selects, all four modes, programmable SCLK divider.
// Bus events fire on strobe rising edges; one byte takes 17*(DIV+1) CLKs, WAIT holds off DATA accesses/writes meanwhile.
module master_spi_multi #(
  parameter int NCS         = 4,
  parameter int DIVW        = 8,
  parameter int DEFAULT_DIV = 0
) (
  input  logic               CLK,
  input  logic               nRST,
  master_spi_multi_if.slave  bus
);
  logic            r_iowr_q, r_iord_q;
  logic [7:0]      r_din;
  logic [1:0]      r_awr, r_ard;
  logic [4:0]      r_ctrl;
  logic [DIVW-1:0] r_div, r_cnt;
  logic [7:0]      r_tx, r_rxsh, r_rx;
  logic [4:0]      r_edges;
  logic            r_busy, r_last, r_ss_act, r_sclk, r_mosi;

  logic            w_wr_ev, w_rd_ev, w_sample, w_start;
  logic [7:0]      w_start_dat;
  logic [NCS-1:0]  w_ss;
  logic [7:0]      w_dout;
  logic            w_unused;

  assign w_wr_ev  = !r_iowr_q && bus.IOWR;
  assign w_rd_ev  = !r_iord_q && bus.IORD && !w_wr_ev;
  // Next SCLK edge is odd when r_edges is even; CPHA flips which parity samples MISO.
  assign w_sample = !r_edges[0] ^ r_ctrl[0];
  assign w_unused = &{1'b0, bus.A[15:3], bus.A[0]};

  always_comb begin
    w_start     = 1'b0;
    w_start_dat = 8'hFF;
    if (!r_busy) begin
      if (w_wr_ev && !r_awr[1]) begin
        w_start     = 1'b1;
        w_start_dat = r_din;
      end else if (w_rd_ev && r_ard == 2'b00) begin
        w_start     = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_iowr_q <= 1'b1;
      r_iord_q <= 1'b1;
      r_din    <= '0;
      r_awr    <= '0;
      r_ard    <= '0;
    end else begin
      r_iowr_q <= bus.IOWR;
      r_iord_q <= bus.IORD;
      if (!bus.IOWR) begin
        r_din <= bus.D_in;
        r_awr <= bus.A[2:1];
      end
      if (!bus.IORD) r_ard <= bus.A[2:1];
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_ctrl   <= '0;
      r_div    <= DIVW'(DEFAULT_DIV);
      r_cnt    <= '0;
      r_tx     <= '0;
      r_rxsh   <= '0;
      r_rx     <= '0;
      r_edges  <= '0;
      r_busy   <= 1'b0;
      r_last   <= 1'b0;
      r_ss_act <= 1'b0;
      r_sclk   <= 1'b0;
      r_mosi   <= 1'b0;
    end else if (w_start) begin
      r_busy   <= 1'b1;
      r_ss_act <= 1'b1;
      r_last   <= w_wr_ev & r_awr[0];
      r_tx     <= w_start_dat;
      r_mosi   <= w_start_dat[7];
      r_cnt    <= r_div;
      r_edges  <= '0;
    end else if (!r_busy) begin
      if (w_wr_ev && r_awr == 2'b10) begin
        r_ctrl   <= r_din[4:0];
        r_ss_act <= 1'b0;
        r_sclk   <= r_din[1];
      end
      if (w_wr_ev && r_awr == 2'b11) r_div <= r_din[DIVW-1:0];
      if (w_rd_ev && r_ard == 2'b01) r_ss_act <= 1'b0;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - DIVW'(1);
    end else begin
      r_cnt <= r_div;
      if (r_edges != 5'd16) begin
        r_edges <= r_edges + 5'd1;
        r_sclk  <= !r_sclk;
        if (w_sample) begin
          r_rxsh <= {r_rxsh[6:0], bus.MISO};
        end else begin
          // CPHA=1 presents the current MSB; CPHA=0 already showed it and advances.
          r_mosi <= r_ctrl[0] ? r_tx[7] : r_tx[6];
          r_tx   <= {r_tx[6:0], 1'b0};
        end
      end else begin
        r_busy <= 1'b0;
        r_rx   <= r_rxsh;
        if (r_last) r_ss_act <= 1'b0;
      end
    end
  end

  always_comb begin
    w_ss = '1;
    for (int i = 0; i < NCS; i++) begin
      if (r_ss_act && r_ctrl[4:2] == 3'(i)) w_ss[i] = 1'b0;
    end
  end

  always_comb begin
    w_dout = r_rx;
    case (bus.A[2:1])
      2'b10:   w_dout = {r_busy, 2'b00, r_ctrl};
      2'b11:   w_dout = 8'(r_div);
      default: w_dout = r_rx;
    endcase
  end

  assign bus.D_out = w_dout;
  assign bus.SS    = w_ss;
  assign bus.SCLK  = r_sclk;
  assign bus.MOSI  = r_mosi;
  assign bus.DDIR  = !bus.IORD;
  assign bus.WAIT  = !(r_busy && (!bus.IOWR || (!bus.IORD && !bus.A[2])));
endmodule

// File: tb/tb_master_spi_multi.sv
// Bench for master_spi_multi: a behavioural SPI slave watches SCLK edges and checks bytes, timing and chip selects.
module tb_master_spi_multi;
  localparam int NCS = 4;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int   n_err = 0;
  int   n_chk = 0;

  master_spi_multi_if #(.NCS(NCS)) bus();

  master_spi_multi #(.NCS(NCS), .DIVW(8), .DEFAULT_DIV(0)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  always #5 CLK = ~CLK;

  function automatic logic [NCS-1:0] exp_ss(input int cs);
    exp_ss = '1;
    if (cs < NCS) exp_ss[cs] = 1'b0;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.A = {13'd0, a, 1'b0};
    bus.D_in = d;
    bus.IOWR = 1'b0;
    tick();
    bus.IOWR = 1'b1;
    tick();
    bus.A = 16'h0004;
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d, output logic ddir);
    bus.A = {13'd0, a, 1'b0};
    bus.IORD = 1'b0;
    tick();
    d = bus.D_out;
    ddir = bus.DDIR;
    bus.IORD = 1'b1;
    tick();
    bus.A = 16'h0004;
    #1;
  endtask

  // SPI slave: samples MOSI on its sampling edges, shifts its own byte out on the others.
  task automatic xfer(input bit cpha, input int div, input logic [7:0] sbyte, input bit loop,
                      input logic [NCS-1:0] ess, output logic [7:0] mbyte, output int bcyc,
                      output int nedge, output int hp_bad, output int ss_bad);
    logic [7:0] sb;
    logic       prev;
    int         last;
    sb = sbyte; mbyte = '0; bcyc = 0; nedge = 0; hp_bad = 0; ss_bad = 0; last = 0;
    prev = bus.SCLK;
    if (!cpha && !loop) begin
      bus.MISO = sb[7];
      sb = sb << 1;
    end
    while (bus.D_out[7] === 1'b1 && bcyc < 4000) begin
      if (bus.SS !== ess) ss_bad++;
      bcyc++;
      if (loop) bus.MISO = bus.MOSI;
      tick();
      if (bus.SCLK !== prev) begin
        nedge++;
        if (bcyc - last != div + 1) hp_bad++;
        last = bcyc;
        if ((nedge % 2 == 1) ^ cpha) mbyte = {mbyte[6:0], bus.MOSI};
        else if (!loop) begin
          bus.MISO = sb[7];
          sb = sb << 1;
        end
        prev = bus.SCLK;
      end
    end
  endtask

  task automatic test_reset();
    bus.A = 16'h0; bus.D_in = 8'h0; bus.IOWR = 1'b1; bus.IORD = 1'b1; bus.MISO = 1'b0;
    nRST = 1'b0;
    repeat (3) tick();
    nRST = 1'b1;
    tick();
    n_chk++; if (bus.SS !== 4'hF) begin n_err++; $display("FAIL reset_ss got=%b exp=1111", bus.SS); end
    n_chk++; if (bus.SCLK !== 1'b0) begin n_err++; $display("FAIL reset_sclk got=%b exp=0", bus.SCLK); end
    n_chk++; if (bus.MOSI !== 1'b0) begin n_err++; $display("FAIL reset_mosi got=%b exp=0", bus.MOSI); end
    n_chk++; if (bus.WAIT !== 1'b1) begin n_err++; $display("FAIL reset_wait got=%b exp=1", bus.WAIT); end
    n_chk++; if (bus.DDIR !== 1'b0) begin n_err++; $display("FAIL reset_ddir got=%b exp=0", bus.DDIR); end
    n_chk++; if (bus.D_out !== 8'h00) begin n_err++; $display("FAIL reset_rx got=%h exp=00", bus.D_out); end
    bus.A = 16'h0004; #1;
    n_chk++; if (bus.D_out !== 8'h00) begin n_err++; $display("FAIL reset_ctrl got=%h exp=00", bus.D_out); end
    bus.A = 16'h0006; #1;
    n_chk++; if (bus.D_out !== 8'h00) begin n_err++; $display("FAIL reset_div got=%h exp=00", bus.D_out); end
  endtask

  task automatic test_mode0_last();
    logic [7:0] mb; int bc, ne, hb, sb;
    wr(2'b01, 8'hA5);
    n_chk++; if (bus.D_out[7] !== 1'b1) begin n_err++; $display("FAIL m0_busy_start got=%b exp=1", bus.D_out[7]); end
    n_chk++; if (bus.SS !== exp_ss(0)) begin n_err++; $display("FAIL m0_ss_start got=%b exp=%b", bus.SS, exp_ss(0)); end
    n_chk++; if (bus.MOSI !== 1'b1) begin n_err++; $display("FAIL m0_mosi_bit7 got=%b exp=1", bus.MOSI); end
    xfer(1'b0, 0, 8'h00, 1'b1, exp_ss(0), mb, bc, ne, hb, sb);
    n_chk++; if (mb !== 8'hA5) begin n_err++; $display("FAIL m0_mosi_byte got=%h exp=a5", mb); end
    n_chk++; if (bc != 17) begin n_err++; $display("FAIL m0_busy_len got=%0d exp=17", bc); end
    n_chk++; if (ne != 16 || hb != 0 || sb != 0) begin n_err++; $display("FAIL m0_sclk got edges=%0d hp_bad=%0d ss_bad=%0d exp 16/0/0", ne, hb, sb); end
    n_chk++; if (bus.SS !== 4'hF) begin n_err++; $display("FAIL m0_ss_release got=%b exp=1111", bus.SS); end
    bus.A = 16'h0000; #1;
    n_chk++; if (bus.D_out !== 8'hA5) begin n_err++; $display("FAIL m0_rx got=%h exp=a5", bus.D_out); end
  endtask

  task automatic test_mode3_hold();
    logic [7:0] mb; int bc, ne, hb, sb;
    wr(2'b10, 8'h0B);
    n_chk++; if (bus.SCLK !== 1'b1) begin n_err++; $display("FAIL m3_sclk_idle got=%b exp=1", bus.SCLK); end
    wr(2'b11, 8'h03);
    wr(2'b00, 8'h3C);
    n_chk++; if (bus.SS !== exp_ss(2)) begin n_err++; $display("FAIL m3_ss got=%b exp=%b", bus.SS, exp_ss(2)); end
    xfer(1'b1, 3, 8'hC3, 1'b0, exp_ss(2), mb, bc, ne, hb, sb);
    n_chk++; if (mb !== 8'h3C) begin n_err++; $display("FAIL m3_mosi_byte got=%h exp=3c", mb); end
    n_chk++; if (bc != 68) begin n_err++; $display("FAIL m3_busy_len got=%0d exp=68", bc); end
    n_chk++; if (ne != 16 || hb != 0 || sb != 0) begin n_err++; $display("FAIL m3_sclk got edges=%0d hp_bad=%0d ss_bad=%0d exp 16/0/0", ne, hb, sb); end
    n_chk++; if (bus.SS !== exp_ss(2) || bus.SCLK !== 1'b1) begin n_err++; $display("FAIL m3_hold got ss=%b sclk=%b exp ss=%b sclk=1", bus.SS, bus.SCLK, exp_ss(2)); end
    bus.A = 16'h0000; #1;
    n_chk++; if (bus.D_out !== 8'hC3) begin n_err++; $display("FAIL m3_rx got=%h exp=c3", bus.D_out); end
  endtask

  task automatic test_prefetch();
    logic [7:0] d, mb, r; logic dd; int bc, ne, hb, sb, act;
    r = 8'($urandom);
    rd(2'b00, d, dd);
    n_chk++; if (d !== 8'hC3 || dd !== 1'b1) begin n_err++; $display("FAIL pf_read got=%h ddir=%b exp=c3 ddir=1", d, dd); end
    n_chk++; if (bus.D_out[7] !== 1'b1) begin n_err++; $display("FAIL pf_busy got=%b exp=1", bus.D_out[7]); end
    xfer(1'b1, 3, r, 1'b0, exp_ss(2), mb, bc, ne, hb, sb);
    n_chk++; if (mb !== 8'hFF || bc != 68 || sb != 0) begin n_err++; $display("FAIL pf_xfer got mosi=%h busy=%0d ss_bad=%0d exp ff/68/0", mb, bc, sb); end
    n_chk++; if (bus.SS !== exp_ss(2)) begin n_err++; $display("FAIL pf_ss_held got=%b exp=%b", bus.SS, exp_ss(2)); end
    rd(2'b01, d, dd);
    n_chk++; if (d !== r) begin n_err++; $display("FAIL pf_last_read got=%h exp=%h", d, r); end
    n_chk++; if (bus.SS !== 4'hF) begin n_err++; $display("FAIL pf_ss_release got=%b exp=1111", bus.SS); end
    act = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.SCLK !== 1'b1 || bus.D_out[7] !== 1'b0) act++;
      tick();
    end
    n_chk++; if (act != 0) begin n_err++; $display("FAIL pf_no_activity got=%0d exp=0", act); end
  endtask

  task automatic test_wait();
    logic [7:0] mb, n, s, d; logic dd; int bc, ne, hb, sb, cyc;
    n = 8'($urandom); s = 8'($urandom);
    wr(2'b10, 8'h00);
    wr(2'b11, 8'h01);
    wr(2'b01, 8'($urandom));
    repeat (3) tick();
    bus.A = 16'h0004; bus.IORD = 1'b0; #1;
    n_chk++; if (bus.D_out[7] !== 1'b1 || bus.WAIT !== 1'b1) begin n_err++; $display("FAIL wt_ctrl_poll got busy=%b wait=%b exp 1/1", bus.D_out[7], bus.WAIT); end
    bus.IORD = 1'b1;
    tick();
    bus.A = 16'h0000; bus.D_in = n; bus.IOWR = 1'b0; #1;
    n_chk++; if (bus.WAIT !== 1'b0) begin n_err++; $display("FAIL wt_assert got=%b exp=0", bus.WAIT); end
    cyc = 4;
    while (bus.WAIT === 1'b0 && cyc < 200) begin
      tick();
      cyc++;
    end
    n_chk++; if (cyc != 34) begin n_err++; $display("FAIL wt_release_cycle got=%0d exp=34", cyc); end
    bus.IOWR = 1'b1;
    tick();
    bus.A = 16'h0004; #1;
    n_chk++; if (bus.D_out[7] !== 1'b1) begin n_err++; $display("FAIL wt_new_busy got=%b exp=1", bus.D_out[7]); end
    xfer(1'b0, 1, s, 1'b0, exp_ss(0), mb, bc, ne, hb, sb);
    n_chk++; if (mb !== n || bc != 34 || sb != 0) begin n_err++; $display("FAIL wt_xfer got mosi=%h busy=%0d ss_bad=%0d exp %h/34/0", mb, bc, sb, n); end
    rd(2'b01, d, dd);
    n_chk++; if (d !== s || bus.SS !== 4'hF) begin n_err++; $display("FAIL wt_rx_release got rx=%h ss=%b exp %h/1111", d, bus.SS, s); end
  endtask

  task automatic test_cs_none();
    logic [7:0] mb, b, s; int bc, ne, hb, sb;
    b = 8'($urandom); s = 8'($urandom);
    wr(2'b10, 8'h14);
    wr(2'b01, b);
    n_chk++; if (bus.D_out[7] !== 1'b1 || bus.SS !== 4'hF) begin n_err++; $display("FAIL cs5_start got busy=%b ss=%b exp 1/1111", bus.D_out[7], bus.SS); end
    xfer(1'b0, 1, s, 1'b0, 4'hF, mb, bc, ne, hb, sb);
    n_chk++; if (mb !== b || bc != 34 || sb != 0 || ne != 16) begin n_err++; $display("FAIL cs5_xfer got mosi=%h busy=%0d ss_bad=%0d edges=%0d exp %h/34/0/16", mb, bc, sb, ne, b); end
    bus.A = 16'h0000; #1;
    n_chk++; if (bus.D_out !== s) begin n_err++; $display("FAIL cs5_rx got=%h exp=%h", bus.D_out, s); end
  endtask

  task automatic test_simul();
    logic [7:0] mb, d; logic dd; int bc, ne, hb, sb;
    wr(2'b10, 8'h00);
    bus.A = 16'h0000; bus.D_in = 8'h42; bus.IORD = 1'b0; bus.IOWR = 1'b0;
    tick();
    bus.IORD = 1'b1; bus.IOWR = 1'b1;
    tick();
    bus.A = 16'h0004; #1;
    n_chk++; if (bus.D_out[7] !== 1'b1 || bus.SS !== exp_ss(0)) begin n_err++; $display("FAIL sim_start got busy=%b ss=%b exp 1/%b", bus.D_out[7], bus.SS, exp_ss(0)); end
    xfer(1'b0, 1, 8'h99, 1'b0, exp_ss(0), mb, bc, ne, hb, sb);
    n_chk++; if (mb !== 8'h42 || bc != 34) begin n_err++; $display("FAIL sim_write_wins got mosi=%h busy=%0d exp 42/34", mb, bc); end
    rd(2'b01, d, dd);
  endtask

  task automatic test_random();
    logic [7:0] mb, b, s; int bc, ne, hb, sb, cs, dv; bit cpha, cpol, last;
    for (int it = 0; it < 6; it++) begin
      cs = int'($urandom_range(7, 0)); dv = int'($urandom_range(4, 0));
      cpha = 1'($urandom); cpol = 1'($urandom); last = 1'($urandom);
      b = 8'($urandom); s = 8'($urandom);
      wr(2'b10, {3'b000, 3'(cs), cpol, cpha});
      n_chk++; if (bus.SCLK !== cpol || bus.SS !== 4'hF) begin n_err++; $display("FAIL rnd_ctrl it=%0d got sclk=%b ss=%b exp %b/1111", it, bus.SCLK, bus.SS, cpol); end
      wr(2'b11, 8'(dv));
      wr({1'b0, last}, b);
      xfer(cpha, dv, s, 1'b0, exp_ss(cs), mb, bc, ne, hb, sb);
      n_chk++; if (mb !== b || bc != 17 * (dv + 1) || ne != 16 || hb != 0 || sb != 0)
        begin n_err++; $display("FAIL rnd_xfer it=%0d got mosi=%h busy=%0d edges=%0d hp_bad=%0d ss_bad=%0d exp %h/%0d/16/0/0", it, mb, bc, ne, hb, sb, b, 17 * (dv + 1)); end
      n_chk++; if (bus.SS !== (last ? 4'hF : exp_ss(cs)) || bus.SCLK !== cpol)
        begin n_err++; $display("FAIL rnd_end it=%0d got ss=%b sclk=%b exp %b/%b", it, bus.SS, bus.SCLK, last ? 4'hF : exp_ss(cs), cpol); end
      n_chk++; if (bus.D_out !== {3'b000, 3'(cs), cpol, cpha}) begin n_err++; $display("FAIL rnd_ctrl_read it=%0d got=%h", it, bus.D_out); end
      bus.A = 16'h0000; #1;
      n_chk++; if (bus.D_out !== s) begin n_err++; $display("FAIL rnd_rx it=%0d got=%h exp=%h", it, bus.D_out, s); end
    end
  endtask

  task automatic test_reset_mid();
    wr(2'b10, 8'h00);
    wr(2'b11, 8'h02);
    wr(2'b00, 8'h5A);
    repeat (10) tick();
    nRST = 1'b0; #1;
    n_chk++; if (bus.SS !== 4'hF || bus.SCLK !== 1'b0 || bus.WAIT !== 1'b1)
      begin n_err++; $display("FAIL rst_mid_pins got ss=%b sclk=%b wait=%b exp 1111/0/1", bus.SS, bus.SCLK, bus.WAIT); end
    n_chk++; if (bus.D_out !== 8'h00) begin n_err++; $display("FAIL rst_mid_status got=%h exp=00", bus.D_out); end
    bus.A = 16'h0000; #1;
    n_chk++; if (bus.D_out !== 8'h00) begin n_err++; $display("FAIL rst_mid_rx got=%h exp=00", bus.D_out); end
    tick();
    nRST = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_mode0_last();
    test_mode3_hold();
    test_prefetch();
    test_wait();
    test_cs_none();
    test_simul();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
